ram_wr_arbiter: RTL and testbench

RAM_WR_ARBITER -- requirements
Module: ram_wr_arbiter

---
 rtl/ram_wr_arbiter.sv | 80 ++++++++
 tb/tb_ram_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - CPU/loader write arbiter for the shared RAM and LED I/O write bus
// One registered write per cycle; CPU-priority RUN mode with loader burst relief, loader-only LOAD mode.
module ram_wr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_wreq,
  input  logic [7:0] cpu_wadr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_wack,
  input  logic       ld_wreq,
  input  logic [7:0] ld_wadr,
  input  logic [7:0] ld_wdata,
  output logic       ld_wack,
  input  logic       ld_mode,
  output logic [7:0] ram_wadr,
  output logic [7:0] ram_wdata,
  output logic       ram_wen
);

  typedef enum logic {RUN, LOAD} state_t;

  state_t     state, state_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic       cpu_elig, ld_elig, burst_hit;
  logic       cpu_gnt, ld_gnt;

  always_comb begin
    state_nxt = ld_mode ? LOAD : RUN;
    // a requester acked this cycle is still holding the same write; skip it once
    cpu_elig  = cpu_wreq & ~cpu_wack;
    ld_elig   = ld_wreq & ~ld_wack;
    burst_hit = (burst_cnt >= 4'(MAX_BURST));
    cpu_gnt   = 1'b0;
    ld_gnt    = 1'b0;
    burst_nxt = burst_cnt;

    if (state_nxt == LOAD) begin
      ld_gnt = ld_elig;
    end else if (ld_elig && (burst_hit || !cpu_wreq)) begin
      // a pending CPU request keeps priority until its burst allowance is used
      ld_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_elig;
    end

    if (!ld_wreq || ld_gnt || (state == RUN && state_nxt == LOAD)) begin
      burst_nxt = 4'd0;
    end else if (cpu_gnt && burst_cnt != 4'hF) begin
      burst_nxt = burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      burst_cnt <= 4'd0;
      cpu_wack  <= 1'b0;
      ld_wack   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_wadr  <= 8'h00;
      ram_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      cpu_wack  <= cpu_gnt;
      ld_wack   <= ld_gnt;
      ram_wen   <= cpu_gnt | ld_gnt;
      if (cpu_gnt) begin
        ram_wadr  <= cpu_wadr;
        ram_wdata <= cpu_wdata;
      end else if (ld_gnt) begin
        ram_wadr  <= ld_wadr;
        ram_wdata <= ld_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// tb/tb_ram_wr_arbiter.sv - scoreboard bench for ram_wr_arbiter
// Reference model predicts every write at each edge; a negedge monitor pops and compares.
module tb_ram_wr_arbiter;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wreq = 1'b0;
  logic [7:0] cpu_wadr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_wack;
  logic       ld_wreq = 1'b0;
  logic [7:0] ld_wadr = 8'h00;
  logic [7:0] ld_wdata = 8'h00;
  logic       ld_wack;
  logic       ld_mode = 1'b0;
  logic [7:0] ram_wadr;
  logic [7:0] ram_wdata;
  logic       ram_wen;

  always #5 clk = ~clk;

  ram_wr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wreq(cpu_wreq), .cpu_wadr(cpu_wadr), .cpu_wdata(cpu_wdata), .cpu_wack(cpu_wack),
    .ld_wreq(ld_wreq), .ld_wadr(ld_wadr), .ld_wdata(ld_wdata), .ld_wack(ld_wack),
    .ld_mode(ld_mode),
    .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  typedef struct {
    int         due;
    int         who;   // 1 = CPU, 2 = loader
    logic [7:0] adr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         log_q[$];
  bit          log_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  bit          cpu_on = 1'b0, ld_on = 1'b0, cpu_fixed = 1'b0;
  int          cpu_pct = 100, ld_pct = 100;
  logic [15:0] ld_script[$];

  // reference model: decides the grant from the arbitration rules at every edge
  initial begin
    int   who;
    bit   c_el, l_el, m_cpu_ack, m_ld_ack;
    int   m_burst;
    m_cpu_ack = 0; m_ld_ack = 0; m_burst = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_cpu_ack = 0; m_ld_ack = 0; m_burst = 0;
      end else begin
        c_el = cpu_wreq && !m_cpu_ack;
        l_el = ld_wreq && !m_ld_ack;
        who = 0;
        if (ld_mode) begin
          if (l_el) who = 2;
        end else if (l_el && (!cpu_wreq || m_burst >= MAX_BURST)) begin
          who = 2;
        end else if (c_el) begin
          who = 1;
        end
        if (ld_mode || !ld_wreq || who == 2) m_burst = 0;
        else if (who == 1 && m_burst < 15) m_burst++;
        cyc++;
        if (who == 1) exp_q.push_back('{cyc, 1, cpu_wadr, cpu_wdata});
        if (who == 2) exp_q.push_back('{cyc, 2, ld_wadr, ld_wdata});
        m_cpu_ack = (who == 1);
        m_ld_ack  = (who == 2);
      end
    end
  end

  // monitor
  initial begin
    wr_t        e;
    int         obs;
    logic [7:0] last_adr, last_data;
    bit         prev_c, prev_l;
    last_adr = 8'h00; last_data = 8'h00; prev_c = 0; prev_l = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_adr = 8'h00; last_data = 8'h00; prev_c = 0; prev_l = 0;
      end else begin
        checks++;
        if ((cpu_wack && ld_wack) || ((cpu_wack || ld_wack) && !ram_wen)) begin
          failures++;
          $display("FAIL ack_excl cyc=%0d cpu_wack=%b ld_wack=%b ram_wen=%b", cyc, cpu_wack, ld_wack, ram_wen);
        end
        if (ram_wen) begin
          obs = cpu_wack ? 1 : (ld_wack ? 2 : 0);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d who=%0d adr=%h data=%h expected none", cyc, obs, ram_wadr, ram_wdata);
          end else begin
            e = exp_q.pop_front();
            if (e.due != cyc || e.who != obs || e.adr != ram_wadr || e.data != ram_wdata) begin
              failures++;
              $display("FAIL write cyc=%0d got who=%0d adr=%h data=%h, expected cyc=%0d who=%0d adr=%h data=%h",
                       cyc, obs, ram_wadr, ram_wdata, e.due, e.who, e.adr, e.data);
            end
          end
          if (cpu_wack || ld_wack) begin
            checks++;
            if ((cpu_wack && prev_c) || (ld_wack && prev_l)) begin
              failures++;
              $display("FAIL double_ack cyc=%0d cpu=%b/%b ld=%b/%b, expected no back-to-back ack", cyc, prev_c, cpu_wack, prev_l, ld_wack);
            end
          end
          if (log_en) log_q.push_back('{cyc, obs, ram_wadr, ram_wdata});
          last_adr = ram_wadr; last_data = ram_wdata;
        end else begin
          checks++;
          if (ram_wadr != last_adr || ram_wdata != last_data) begin
            failures++;
            $display("FAIL hold cyc=%0d got adr=%h data=%h, expected adr=%h data=%h", cyc, ram_wadr, ram_wdata, last_adr, last_data);
          end
          if (exp_q.size() > 0) begin
            checks++;
            if (exp_q[0].due <= cyc) begin
              failures++;
              $display("FAIL missed_write cyc=%0d got ram_wen=0, expected who=%0d adr=%h", cyc, exp_q[0].who, exp_q[0].adr);
              void'(exp_q.pop_front());
            end
          end
        end
        prev_c = cpu_wack; prev_l = ld_wack;
      end
    end
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ram_wen"},   {7'd0, ram_wen},  8'h00);
    check({tag, "_cpu_wack"},  {7'd0, cpu_wack}, 8'h00);
    check({tag, "_ld_wack"},   {7'd0, ld_wack},  8'h00);
    check({tag, "_ram_wadr"},  ram_wadr,         8'h00);
    check({tag, "_ram_wdata"}, ram_wdata,        8'h00);
  endtask

  task automatic drive_cycle();
    logic [15:0] s;
    @(negedge clk);
    #1;
    if (cpu_wreq && cpu_wack) cpu_wreq = 1'b0;
    if (ld_wreq && ld_wack) ld_wreq = 1'b0;
    if (!cpu_wreq && cpu_on && $urandom_range(99) < cpu_pct) begin
      cpu_wreq = 1'b1;
      if (!cpu_fixed) begin
        cpu_wadr  = 8'($urandom);
        cpu_wdata = 8'($urandom);
      end
    end
    if (!ld_wreq && ld_on && $urandom_range(99) < ld_pct) begin
      ld_wreq = 1'b1;
      if (ld_script.size() > 0) begin
        s = ld_script.pop_front();
        ld_wadr  = s[15:8];
        ld_wdata = s[7:0];
      end else begin
        ld_wadr  = 8'($urandom);
        ld_wdata = 8'($urandom);
      end
    end
  endtask

  task automatic drain();
    cpu_on = 1'b0; ld_on = 1'b0;
    repeat (6) drive_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_cpu, n_ld;
    bit found;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // single CPU write to LED I/O
    cpu_fixed = 1'b1; cpu_wadr = 8'hFD; cpu_wdata = 8'hFF;
    cpu_on = 1'b1; cpu_pct = 100; ld_pct = 100;
    drive_cycle();
    cpu_on = 1'b0;
    drive_cycle();
    check("single_cpu_wack", {7'd0, cpu_wack}, 8'h01);
    check("single_cpu_adr", ram_wadr, 8'hFD);
    repeat (2) drive_cycle();

    // CPU holding one request: alternate-cycle writes
    cpu_wadr = 8'h21; cpu_wdata = 8'h43; cpu_on = 1'b1;
    repeat (4) drive_cycle();
    drain();
    cpu_fixed = 1'b0;

    // continuous contention: MAX_BURST CPU grants then one loader grant
    log_q.delete(); log_en = 1'b1;
    cpu_on = 1'b1; ld_on = 1'b1;
    repeat (40) drive_cycle();
    log_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i].who != ((i % (MAX_BURST + 1) == MAX_BURST) ? 2 : 1)) begin
        failures++;
        $display("FAIL burst_pattern idx=%0d got who=%0d expected who=%0d", i,
                 (i < log_q.size()) ? log_q[i].who : 0, (i % (MAX_BURST + 1) == MAX_BURST) ? 2 : 1);
      end
    end
    drain();

    // loader exclusive mode stalls the CPU
    log_q.delete(); log_en = 1'b1;
    ld_mode = 1'b1; cpu_on = 1'b1; ld_on = 1'b1;
    repeat (12) drive_cycle();
    log_en = 1'b0;
    n_cpu = 0; n_ld = 0;
    foreach (log_q[i]) begin
      if (log_q[i].who == 1) n_cpu++;
      if (log_q[i].who == 2) n_ld++;
    end
    check("load_cpu_grants", 8'(n_cpu), 8'd0);
    check("load_ld_grants_min5", {7'd0, n_ld >= 5}, 8'h01);
    ld_mode = 1'b0; ld_on = 1'b0;
    drive_cycle();
    check("run_return_cpu_wack", {7'd0, cpu_wack}, 8'h01);
    drain();

    // loader LED sequence passes through unmodified, in order
    ld_script.push_back(16'hFE00);
    ld_script.push_back(16'hFEFF);
    log_q.delete(); log_en = 1'b1; ld_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      if (ld_script.size() == 0) ld_on = 1'b0;
      if (!ld_on && !ld_wreq) break;
    end
    repeat (2) drive_cycle();
    log_en = 1'b0;
    check("ld_seq_count_min2", {7'd0, log_q.size() >= 2}, 8'h01);
    if (log_q.size() >= 2) begin
      check("ld_seq0_adr", log_q[0].adr, 8'hFE);
      check("ld_seq0_data", log_q[0].data, 8'h00);
      check("ld_seq1_adr", log_q[1].adr, 8'hFE);
      check("ld_seq1_data", log_q[1].data, 8'hFF);
    end
    ld_on = 1'b0;
    drain();

    // randomized traffic with ld_mode toggling
    cpu_pct = 60; ld_pct = 45;
    cpu_on = 1'b1; ld_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive_cycle();
      if ($urandom_range(99) < 10) ld_mode = ~ld_mode;
    end

    // asynchronous reset in a write cycle
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle();
      if (ram_wen) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_wait got no ram_wen within 50 cycles, expected a write");
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwrite_reset");
    cpu_on = 1'b0; ld_on = 1'b0; ld_mode = 1'b0; ld_wreq = 1'b0;
    cpu_wreq = 1'b1; cpu_wadr = 8'hFD; cpu_wdata = 8'h5A;
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    drive_cycle();
    check("post_reset_cpu_wack", {7'd0, cpu_wack}, 8'h01);
    check("post_reset_wdata", ram_wdata, 8'h5A);
    drain();

    ld_mode = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_writes got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
